iir_coef_loader: RTL and testbench

Byte-stream coefficient writer for the programmable biquad IIR filter. It parses framed commands from a byte source, such as a UART receiver or a host bridge, into five shadow coefficient registers. On command, it commits them atomically to the active coefficient outputs that drive the filter's b0, b1, b2, a1 and a2 inputs. Commits are applied only on a sample boundary, so the filter never computes one output from a mix of old and new coefficients.

---
 rtl/iir_coef_loader.sv | 180 ++++++++++++++++++
 tb/tb_iir_coef_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_coef_loader.sv
// rtl/iir_coef_loader.sv - framed byte-stream loader for biquad IIR coefficients with sample-aligned commit
// Optional feature: define CKSUM_EN for 5-byte frames with a trailing XOR checksum.
module iir_coef_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] B0_INIT   = 16'h000E,
  parameter logic [15:0] B1_INIT   = 16'h0011,
  parameter logic [15:0] B2_INIT   = 16'h000E,
  parameter logic [15:0] A1_INIT   = 16'h01C0,
  parameter logic [15:0] A2_INIT   = 16'h07F2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        sample_strobe,
  output logic [15:0] b0,
  output logic [15:0] b1,
  output logic [15:0] b2,
  output logic [15:0] a1,
  output logic [15:0] a2,
  output logic        coef_update,
  output logic        err
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_IDX,
    S_HI,
    S_LO,
`ifdef CKSUM_EN
    S_CK,
`endif
    S_PEND
  } state_t;

  localparam logic [15:0] INIT_VAL [5] = '{B0_INIT, B1_INIT, B2_INIT, A1_INIT, A2_INIT};
  localparam logic [2:0]  IDX_COMMIT   = 3'd5;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  hi_q, hi_d;
`ifdef CKSUM_EN
  logic [7:0]  lo_q, lo_d;
`endif
  logic [15:0] shadow_q [5];
  logic [15:0] shadow_d [5];
  logic [15:0] active_q [5];
  logic [15:0] active_d [5];
  logic        coef_update_q, coef_update_d;
  logic        err_q, err_d;

  logic        xfer;
  logic        frame_done;
  logic [15:0] frame_data;

  assign in_ready = (state_q != S_PEND);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    hi_d          = hi_q;
`ifdef CKSUM_EN
    lo_d          = lo_q;
`endif
    shadow_d      = shadow_q;
    active_d      = active_q;
    coef_update_d = 1'b0;
    err_d         = 1'b0;
    frame_done    = 1'b0;
    frame_data    = '0;

    case (state_q)
      S_HUNT: begin
        if (xfer && in_data == SYNC_BYTE) state_d = S_IDX;
      end
      S_IDX: begin
        if (xfer) begin
          idx_d = in_data[2:0];
          if (in_data > 8'd5) begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end else begin
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d    = in_data;
          state_d = S_LO;
        end
      end
`ifdef CKSUM_EN
      S_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          state_d = S_CK;
        end
      end
      S_CK: begin
        if (xfer) begin
          if (in_data == ({5'd0, idx_q} ^ hi_q ^ lo_q)) begin
            frame_done = 1'b1;
            frame_data = {hi_q, lo_q};
          end else begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end
        end
      end
`else
      S_LO: begin
        if (xfer) begin
          frame_done = 1'b1;
          frame_data = {hi_q, in_data};
        end
      end
`endif
      S_PEND: begin
        // Only a strobe seen while already pending commits; entry-cycle strobes are ignored.
        if (sample_strobe) begin
          active_d      = shadow_q;
          coef_update_d = 1'b1;
          state_d       = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase

    if (frame_done) begin
      if (idx_q == IDX_COMMIT) begin
        state_d = S_PEND;
      end else begin
        state_d = S_HUNT;
        for (int i = 0; i < 5; i++) begin
          if (idx_q == 3'(i)) shadow_d[i] = frame_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_HUNT;
      idx_q         <= '0;
      hi_q          <= '0;
`ifdef CKSUM_EN
      lo_q          <= '0;
`endif
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= INIT_VAL[i];
        active_q[i] <= INIT_VAL[i];
      end
      coef_update_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hi_q          <= hi_d;
`ifdef CKSUM_EN
      lo_q          <= lo_d;
`endif
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      coef_update_q <= coef_update_d;
      err_q         <= err_d;
    end
  end

  assign b0          = active_q[0];
  assign b1          = active_q[1];
  assign b2          = active_q[2];
  assign a1          = active_q[3];
  assign a2          = active_q[4];
  assign coef_update = coef_update_q;
  assign err         = err_q;

endmodule

// File: tb/tb_iir_coef_loader.sv
// tb/tb_iir_coef_loader.sv - randomized frame-level checks of iir_coef_loader against a coefficient-bank model
module tb_iir_coef_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        sample_strobe;
  logic [15:0] b0, b1, b2, a1, a2;
  logic        coef_update;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] init_val [5];
  logic [15:0] m_shadow [5];
  logic [15:0] m_active [5];
  logic [15:0] dut_out [5];

  always #5 clk = ~clk;

  iir_coef_loader dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .sample_strobe (sample_strobe),
    .b0            (b0),
    .b1            (b1),
    .b2            (b2),
    .a1            (a1),
    .a2            (a2),
    .coef_update   (coef_update),
    .err           (err)
  );

  always_comb begin
    dut_out[0] = b0;
    dut_out[1] = b1;
    dut_out[2] = b2;
    dut_out[3] = a1;
    dut_out[4] = a2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    for (int i = 0; i < 5; i++) check($sformatf("%s.coef%0d", tag, i), dut_out[i], m_active[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_shadow[i] = init_val[i];
      m_active[i] = init_val[i];
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic s);
    in_valid      = v;
    in_data       = d;
    sample_strobe = s;
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    sample_strobe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_err, input logic exp_ready, input logic s);
    step(1'b1, d, s);
    check("err", err, exp_err);
    check("coef_update_idle", coef_update, 1'b0);
    check("in_ready", in_ready, exp_ready);
  endtask

  function automatic logic [7:0] non_sync_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hA5) b = 8'h5A;
    return b;
  endfunction

  // Sends one frame; returns 1 when a commit is now pending in the model.
  task automatic send_frame(input int idx, input logic [15:0] val, input logic bad_ck,
                            input logic strobe_last, output logic pending);
    logic [7:0] ib, hi, lo, last;
    logic       ok;
    ib      = 8'(idx);
    hi      = val[15:8];
    lo      = val[7:0];
    pending = 1'b0;
    send_byte(8'hA5, 1'b0, 1'b1, 1'b0);
    if (idx > 5) begin
      send_byte(ib, 1'b1, 1'b1, 1'b0);
      send_byte(non_sync_byte(), 1'b0, 1'b1, 1'b0);
      send_byte(non_sync_byte(), 1'b0, 1'b1, 1'b0);
      check_outs("bad_idx");
      return;
    end
    send_byte(ib, 1'b0, 1'b1, 1'b0);
    send_byte(hi, 1'b0, 1'b1, 1'b0);
`ifdef CKSUM_EN
    send_byte(lo, 1'b0, 1'b1, 1'b0);
    last = ib ^ hi ^ lo ^ (bad_ck ? 8'(1 + $urandom_range(0, 254)) : 8'h00);
    ok   = !bad_ck;
`else
    last = lo;
    ok   = 1'b1;
`endif
    send_byte(last, !ok, !(ok && idx == 5), strobe_last);
    if (ok && idx < 5) m_shadow[idx] = val;
    if (ok && idx == 5) pending = 1'b1;
    check_outs("frame_end");
  endtask

  task automatic commit_wait(input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      step(1'b1, 8'($urandom), 1'b0);
      check("pend_ready", in_ready, 1'b0);
      check("pend_update", coef_update, 1'b0);
      check_outs("pend_hold");
    end
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
    check("commit_update", coef_update, 1'b1);
    check("commit_ready", in_ready, 1'b1);
    check_outs("commit");
    step(1'b0, 8'h00, 1'b0);
    check("update_pulse_end", coef_update, 1'b0);
  endtask

  initial begin
    logic       pend;
    int         idx;
    logic [15:0] val;
    logic       bad;

    init_val = '{16'h000E, 16'h0011, 16'h000E, 16'h01C0, 16'h07F2};
    model_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; sample_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1'b1);
    check("rst_update", coef_update, 1'b0);
    check("rst_err", err, 1'b0);
    check_outs("rst");
    rst = 1'b1;
    repeat (3) begin
      step(1'b0, 8'h00, 1'b1);
      check("idle_update", coef_update, 1'b0);
      check("idle_err", err, 1'b0);
    end

    // Basic write then commit, with strobe 3 cycles later.
    send_frame(0, 16'h1234, 1'b0, 1'b0, pend);
    send_frame(5, 16'h0000, 1'b0, 1'b0, pend);
    check("commit_pending", pend, 1'b1);
    commit_wait(2);
    check("b0_1234", b0, 16'h1234);

    // All five indices, index 2 rewritten, strobe on commit's last byte must be ignored.
    for (int i = 0; i < 5; i++) send_frame(i, 16'(i + 1), 1'b0, 1'b0, pend);
    send_frame(2, 16'h7FFF, 1'b0, 1'b0, pend);
    send_frame(5, 16'hA5A5, 1'b0, 1'b1, pend);
    commit_wait(1);
    check("b2_7fff", b2, 16'h7FFF);
    check("a2_0005", a2, 16'h0005);

    // Invalid index.
    send_frame(7, 16'h1122, 1'b0, 1'b0, pend);
`ifdef CKSUM_EN
    send_frame(1, 16'hABCD, 1'b1, 1'b0, pend);
    send_frame(5, 16'h0000, 1'b0, 1'b0, pend);
    commit_wait(0);
    check("b1_kept", b1, 16'h0002);
`endif

    // Reset while a commit is pending.
    send_frame(3, 16'hBEEF, 1'b0, 1'b0, pend);
    send_frame(5, 16'h0000, 1'b0, 1'b0, pend);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst_pend_ready", in_ready, 1'b1);
    check_outs("rst_pend");
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    check("rst_no_update", coef_update, 1'b0);
    check_outs("rst_after_strobe");

    // Reset mid-frame.
    send_byte(8'hA5, 1'b0, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    check_outs("rst_mid");

    // Randomized frames, garbage and stray strobes.
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0: begin
          send_byte(non_sync_byte(), 1'b0, 1'b1, 1'b0);
        end
        1: begin
          step(1'b0, 8'h00, 1'b1);
          check("stray_strobe", coef_update, 1'b0);
          check_outs("stray");
        end
        default: begin
          idx = $urandom_range(0, 9);
          if (idx > 6) idx = $urandom_range(0, 5);
          if (idx == 6) idx = $urandom_range(6, 255);
          val = 16'($urandom);
          if ($urandom_range(0, 7) == 0) val[15:8] = 8'hA5;
`ifdef CKSUM_EN
          bad = ($urandom_range(0, 5) == 0);
`else
          bad = 1'b0;
`endif
          send_frame(idx, val, bad, 1'($urandom_range(0, 1)), pend);
          if (pend) commit_wait($urandom_range(0, 5));
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
